// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
// State encoding, PC-source selects and a small sizing helper.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StRun,
        StBranchWait,
        StIntDrain,
        StIntInject
    } fetch_state_e;

    localparam logic [1:0] PC_SEL_INC   = 2'b00;
    localparam logic [1:0] PC_SEL_NEW   = 2'b01;
    localparam logic [1:0] PC_SEL_RESET = 2'b10;
    localparam logic [1:0] PC_SEL_INT   = 2'b11;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable saturating down-counter with a zero flag.
// Shared by the branch-wait, interrupt-drain and interrupt-inject phases.
module wait_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencing controller: PC update select, IF/ID bubbles,
// branch-resolution wait and two-phase interrupt entry (drain, then inject).
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned HAZARD_WAIT_MAX = 3,
    parameter int unsigned DRAIN_CYCLES    = 3,
    parameter int unsigned INJECT_CYCLES   = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_interrupt_req,
    input  logic       i_hazard_instruction,
    input  logic       i_stall,
    input  logic       i_branch_resolved,
    input  logic       i_branch_decision,
    output logic       o_pc_enable,
    output logic [1:0] o_pc_sel,
    output logic       o_flush,
    output logic       o_interrupt,
    output logic       o_int_ack,
    output logic       o_busy
);

    localparam int unsigned CntW =
        $clog2(max3(HAZARD_WAIT_MAX, DRAIN_CYCLES, INJECT_CYCLES) + 1);

    localparam logic [CntW-1:0] HazardLoad = CntW'(HAZARD_WAIT_MAX - 1);
    localparam logic [CntW-1:0] DrainLoad  = CntW'(DRAIN_CYCLES - 1);
    localparam logic [CntW-1:0] InjectLoad = CntW'(INJECT_CYCLES - 1);

    fetch_state_e    r_state;
    logic            r_booted;
    logic            r_pending;

    logic            w_cnt_load;
    logic [CntW-1:0] w_cnt_load_value;
    logic            w_cnt_dec;
    logic            w_cnt_zero;
    logic            w_take_int;
    logic            w_take_hazard;

    // RUN-state transitions only fire when fetch is not frozen.
    assign w_take_int    = !i_stall && r_pending && !i_hazard_instruction;
    assign w_take_hazard = !i_stall && i_hazard_instruction;

    wait_counter #(
        .WIDTH(CntW)
    ) u_wait_counter (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (w_cnt_load),
        .i_load_value(w_cnt_load_value),
        .i_dec       (w_cnt_dec),
        .o_zero      (w_cnt_zero)
    );

    always_comb begin
        w_cnt_load       = 1'b0;
        w_cnt_load_value = '0;
        w_cnt_dec        = 1'b0;
        case (r_state)
            StRun: begin
                if (w_take_int) begin
                    w_cnt_load       = 1'b1;
                    w_cnt_load_value = DrainLoad;
                end else if (w_take_hazard) begin
                    w_cnt_load       = 1'b1;
                    w_cnt_load_value = HazardLoad;
                end
            end
            StBranchWait: w_cnt_dec = !i_branch_resolved;
            StIntDrain: begin
                if (w_cnt_zero) begin
                    w_cnt_load       = 1'b1;
                    w_cnt_load_value = InjectLoad;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            StIntInject: w_cnt_dec = 1'b1;
            default: ;
        endcase
    end

    // r_booted holds the reset-value outputs until the first clock edge after release.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= StBoot;
            r_booted  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if ((r_state == StIntDrain) && w_cnt_zero) begin
                r_pending <= 1'b0;
            end else if (i_interrupt_req && (r_state != StIntInject)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                StBoot: begin
                    if (r_booted) begin
                        r_state <= StRun;
                    end else begin
                        r_booted <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_take_int) begin
                        r_state <= StIntDrain;
                    end else if (w_take_hazard) begin
                        r_state <= StBranchWait;
                    end
                end
                StBranchWait: begin
                    if (i_branch_resolved || w_cnt_zero) begin
                        r_state <= StRun;
                    end
                end
                StIntDrain: begin
                    if (w_cnt_zero) begin
                        r_state <= StIntInject;
                    end
                end
                StIntInject: begin
                    if (w_cnt_zero) begin
                        r_state <= StRun;
                    end
                end
                default: r_state <= StBoot;
            endcase
        end
    end

    always_comb begin
        o_pc_enable = 1'b0;
        o_pc_sel    = PC_SEL_INC;
        o_flush     = 1'b0;
        o_interrupt = 1'b0;
        o_int_ack   = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            StBoot: begin
                o_pc_enable = r_booted;
                o_pc_sel    = PC_SEL_RESET;
                o_flush     = 1'b1;
            end
            StRun: begin
                o_busy      = 1'b0;
                o_pc_enable = !i_stall && !w_take_int;
            end
            StBranchWait: begin
                o_flush = 1'b1;
                if (i_branch_resolved) begin
                    o_pc_enable = 1'b1;
                    o_pc_sel    = i_branch_decision ? PC_SEL_NEW : PC_SEL_INC;
                end else if (w_cnt_zero) begin
                    o_pc_enable = 1'b1;
                end
            end
            StIntDrain: begin
                o_flush   = 1'b1;
                o_int_ack = w_cnt_zero;
            end
            StIntInject: begin
                o_flush     = 1'b1;
                o_interrupt = 1'b1;
                o_pc_sel    = PC_SEL_INT;
                o_pc_enable = w_cnt_zero;
            end
            default: ;
        endcase
    end

endmodule
